uart_rx_core: RTL and testbench

- UART receiver stage directly downstream of the UART transmitter in the SPI-to-UART path.
- Takes the serial line driven by the transmitter's txd (8N1, LSB first, idle high) and recovers bytes.
- Feeds rx_data and the new-data flag to the LED/FND display logic in top.
- Two selectable baud rates, both derived from clk by the same divider parameters the transmitter uses, so both ends share one parameter set.

---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_rx_sync.sv | 30 +++
 rtl/uart_rx_core.sv | 143 ++++++++++++++
 tb/tb_uart_rx_core.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants: state codes, data width, simulation divider set
package uart_pkg;

    localparam int DATA_BITS = 8;

    localparam logic [2:0] ST_IDLE_CODE      = 3'd0;
    localparam logic [2:0] ST_START_CODE     = 3'd1;
    localparam logic [2:0] ST_DATA_CODE      = 3'd2;
    localparam logic [2:0] ST_STOP_CODE      = 3'd3;
    localparam logic [2:0] ST_WAIT_IDLE_CODE = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE      = ST_IDLE_CODE,
        ST_START     = ST_START_CODE,
        ST_DATA      = ST_DATA_CODE,
        ST_STOP      = ST_STOP_CODE,
        ST_WAIT_IDLE = ST_WAIT_IDLE_CODE
    } rx_state_t;

    // Short divider set so a frame fits in a few hundred clocks; the transmitter shares it.
    localparam int                     SIM_T_DIV_BIT    = 4;
    localparam logic [SIM_T_DIV_BIT-1:0] SIM_T_DIV_0      = 4'd15;
    localparam logic [SIM_T_DIV_BIT-1:0] SIM_T_DIV_HALF_0 = 4'd7;
    localparam logic [SIM_T_DIV_BIT-1:0] SIM_T_DIV_1      = 4'd7;
    localparam logic [SIM_T_DIV_BIT-1:0] SIM_T_DIV_HALF_1 = 4'd3;

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - two-flop synchronizer for the serial line plus falling-edge detector
module uart_rx_sync (
    input  logic clk,
    input  logic n_rst,
    input  logic rxd,
    output logic rxd_s,
    output logic fall_pulse
);

    logic sync1;
    logic sync2;
    logic hist;

    // Reset to the idle level so release of reset never looks like a start edge.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            hist  <= 1'b1;
        end else begin
            sync1 <= rxd;
            sync2 <= sync1;
            hist  <= sync2;
        end
    end

    assign rxd_s      = sync2;
    assign fall_pulse = hist & ~sync2;

endmodule

// File: rtl/uart_rx_core.sv
// rtl/uart_rx_core.sv - 8N1 UART receiver with two selectable baud rates and sticky new-data/overrun flags
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int                   T_DIV_BIT    = 13,
    parameter logic [T_DIV_BIT-1:0] T_DIV_0      = 13'd5207,
    parameter logic [T_DIV_BIT-1:0] T_DIV_HALF_0 = 13'd2603,
    parameter logic [T_DIV_BIT-1:0] T_DIV_1      = 13'd2603,
    parameter logic [T_DIV_BIT-1:0] T_DIV_HALF_1 = 13'd1301
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 baudrate,
    input  logic                 uart_rxd,
    input  logic                 rx_ack,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 new_data,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    rx_state_t              state;
    logic [T_DIV_BIT-1:0]   cnt;
    logic [2:0]             bit_idx;
    logic [DATA_BITS-1:0]   shreg;
    logic                   rate_q;
    logic                   rxd_s;
    logic                   fall_pulse;
    logic [T_DIV_BIT-1:0]   full_tc;
    logic [T_DIV_BIT-1:0]   half_tc;

    uart_rx_sync u_sync (
        .clk        (clk),
        .n_rst      (n_rst),
        .rxd        (uart_rxd),
        .rxd_s      (rxd_s),
        .fall_pulse (fall_pulse)
    );

    assign full_tc = rate_q ? T_DIV_1      : T_DIV_0;
    assign half_tc = rate_q ? T_DIV_HALF_1 : T_DIV_HALF_0;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            rate_q    <= 1'b0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            new_data  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;

            // A completing byte below overrides this, so completion wins over a same-cycle ack.
            if (rx_ack && new_data) begin
                new_data <= 1'b0;
                overrun  <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (fall_pulse) begin
                        state  <= ST_START;
                        cnt    <= '0;
                        rate_q <= baudrate;
                        busy   <= 1'b1;
                    end
                end

                ST_START: begin
                    if (cnt == half_tc) begin
                        cnt <= '0;
                        if (rxd_s) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state   <= ST_DATA;
                            bit_idx <= '0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                ST_DATA: begin
                    if (cnt == full_tc) begin
                        cnt     <= '0;
                        shreg   <= {rxd_s, shreg[DATA_BITS-1:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == LAST_BIT) begin
                            state <= ST_STOP;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                ST_STOP: begin
                    if (cnt == full_tc) begin
                        cnt <= '0;
                        if (rxd_s) begin
                            rx_data  <= shreg;
                            rx_valid <= 1'b1;
                            overrun  <= overrun | new_data;
                            new_data <= 1'b1;
                            state    <= ST_IDLE;
                            busy     <= 1'b0;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= ST_WAIT_IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                // A held-low line (break) must not be decoded as repeated 0x00 frames.
                ST_WAIT_IDLE: begin
                    if (rxd_s) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_core.sv
// tb/tb_uart_rx_core.sv - randomized self-checking bench for uart_rx_core against a frame-level model
module tb_uart_rx_core;
    import uart_pkg::*;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       baudrate;
    logic       uart_rxd;
    logic       rx_ack;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       new_data;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    uart_rx_core #(
        .T_DIV_BIT    (SIM_T_DIV_BIT),
        .T_DIV_0      (SIM_T_DIV_0),
        .T_DIV_HALF_0 (SIM_T_DIV_HALF_0),
        .T_DIV_1      (SIM_T_DIV_1),
        .T_DIV_HALF_1 (SIM_T_DIV_HALF_1)
    ) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .baudrate  (baudrate),
        .uart_rxd  (uart_rxd),
        .rx_ack    (rx_ack),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .new_data  (new_data),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    localparam int BCLK0 = int'(SIM_T_DIV_0) + 1;
    localparam int BCLK1 = int'(SIM_T_DIV_1) + 1;
    localparam int LAT0  = 2 + 1 + (int'(SIM_T_DIV_HALF_0) + 1) + 9 * BCLK0 + 1;
    localparam int LAT1  = 2 + 1 + (int'(SIM_T_DIV_HALF_1) + 1) + 9 * BCLK1 + 1;

    int         n_vec = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         start_cyc = 0;
    int         last_valid_cyc = 0;
    int         fe_cnt = 0;
    bit         busy_seen = 1'b0;
    logic [7:0] rx_q[$];
    bit         m_nd = 1'b0;
    bit         m_ovr = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (n_rst) begin
            if (rx_valid) begin
                rx_q.push_back(rx_data);
                last_valid_cyc = cyc;
            end
            if (frame_err) fe_cnt++;
            if (busy) busy_seen = 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop, input int bclk);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            if (i == 0) start_cyc = cyc;
            uart_rxd = bits[i];
            repeat (bclk) @(negedge clk);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", 32'(n < 500), 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic do_ack();
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
        if (m_nd) begin
            m_nd  = 1'b0;
            m_ovr = 1'b0;
        end
    endtask

    task automatic model_complete();
        m_ovr = m_ovr | m_nd;
        m_nd  = 1'b1;
    endtask

    task automatic expect_byte(input string tag, input logic [7:0] b);
        check({tag, "_count"}, rx_q.size(), 1);
        if (rx_q.size() > 0) check({tag, "_pulse_data"}, rx_q.pop_front(), b);
        rx_q.delete();
        check({tag, "_rx_data"}, rx_data, b);
        check({tag, "_new_data"}, new_data, m_nd);
        check({tag, "_overrun"}, overrun, m_ovr);
        check({tag, "_busy"}, busy, 0);
    endtask

    task automatic check_lat(input string tag, input int exp);
        int lat;
        lat = last_valid_cyc - start_cyc;
        check(tag, 32'(lat >= exp - 1 && lat <= exp + 1), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int fe0;
        logic [7:0] b;
        int bclk;
        n_rst    = 1'b0;
        baudrate = 1'b0;
        uart_rxd = 1'b1;
        rx_ack   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_rx_data", rx_data, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_new_data", new_data, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_overrun", overrun, 0);
        check("rst_busy", busy, 0);
        n_rst = 1'b1;
        repeat (5) @(negedge clk);

        // single frame, rate 0
        send_frame(8'hC5, 1'b1, BCLK0);
        wait_idle();
        model_complete();
        expect_byte("c5", 8'hC5);
        check_lat("c5_latency", LAT0);
        check("c5_frame_err", fe_cnt, 0);

        // back-to-back without ack -> overrun
        send_frame(8'hC6, 1'b1, BCLK0);
        model_complete();
        send_frame(8'hC7, 1'b1, BCLK0);
        model_complete();
        wait_idle();
        check("b2b_count", rx_q.size(), 2);
        if (rx_q.size() == 2) begin
            check("b2b_first", rx_q[0], 8'hC6);
            check("b2b_second", rx_q[1], 8'hC7);
        end
        rx_q.delete();
        check("b2b_rx_data", rx_data, 8'hC7);
        check("b2b_overrun", overrun, m_ovr);
        do_ack();
        @(negedge clk);
        check("ack_new_data", new_data, 0);
        check("ack_overrun", overrun, 0);

        // rate 1 with baudrate flipped mid-frame
        baudrate = 1'b1;
        fork
            send_frame(8'hA5, 1'b1, BCLK1);
            begin
                repeat (30) @(negedge clk);
                baudrate = 1'b0;
            end
        join
        wait_idle();
        model_complete();
        expect_byte("a5", 8'hA5);
        check_lat("a5_latency", LAT1);

        // bad stop bit then break
        fe0 = fe_cnt;
        send_frame(8'h3C, 1'b0, BCLK0);
        repeat (40) @(negedge clk);
        check("brk_frame_err", fe_cnt - fe0, 1);
        check("brk_no_frames", rx_q.size(), 0);
        check("brk_rx_data", rx_data, 8'hA5);
        check("brk_new_data", new_data, m_nd);
        check("brk_busy", busy, 1);
        uart_rxd = 1'b1;
        wait_idle();
        check("brk_released", busy, 0);
        send_frame(8'h81, 1'b1, BCLK0);
        wait_idle();
        model_complete();
        expect_byte("x81", 8'h81);
        do_ack();

        // short glitch on idle line
        fe0 = fe_cnt;
        busy_seen = 1'b0;
        uart_rxd = 1'b0;
        repeat (5) @(negedge clk);
        uart_rxd = 1'b1;
        repeat (30) @(negedge clk);
        check("glitch_busy_seen", busy_seen, 1);
        check("glitch_busy_end", busy, 0);
        check("glitch_no_valid", rx_q.size(), 0);
        check("glitch_no_ferr", fe_cnt - fe0, 0);

        // asynchronous reset during DATA
        model_complete();
        send_frame(8'h55, 1'b1, BCLK0);
        wait_idle();
        expect_byte("pre_rst", 8'h55);
        fork
            send_frame(8'hFF, 1'b1, BCLK0);
            begin
                repeat (60) @(negedge clk);
                n_rst = 1'b0;
                #1;
                check("arst_rx_data", rx_data, 0);
                check("arst_rx_valid", rx_valid, 0);
                check("arst_new_data", new_data, 0);
                check("arst_frame_err", frame_err, 0);
                check("arst_overrun", overrun, 0);
                check("arst_busy", busy, 0);
                repeat (3) @(negedge clk);
                n_rst = 1'b1;
            end
        join
        m_nd  = 1'b0;
        m_ovr = 1'b0;
        repeat (5) @(negedge clk);
        check("arst_no_partial", rx_q.size(), 0);
        send_frame(8'h12, 1'b1, BCLK0);
        wait_idle();
        model_complete();
        expect_byte("x12", 8'h12);

        // randomized frames, rates, gaps and acks
        for (int k = 0; k < 14; k++) begin
            baudrate = 1'($urandom_range(0, 1));
            bclk = baudrate ? BCLK1 : BCLK0;
            b = 8'($urandom);
            if ($urandom_range(0, 1) == 1) do_ack();
            repeat ($urandom_range(0, 20)) @(negedge clk);
            send_frame(b, 1'b1, bclk);
            wait_idle();
            model_complete();
            expect_byte("rnd", b);
            check_lat("rnd_latency", baudrate ? LAT1 : LAT0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
